inv_shift_rows_iter: RTL and testbench

- InvShiftRows stage for the AES-128 decryption datapath; the inverse of the encryption-side ShiftRows stage.
- Sits between AddRoundKey/InvMixColumns and InvSubBytes in the inverse round.
- Rotates row r of the 4x4 byte state right by r positions, so that out[r][c] = in[r][(c-r) mod 4].
- Two build modes:
  - Iterative: one row per clock, FSM-controlled, with a working register.
  - Single-cycle: registered, one-clock latency.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/inv_row_rotate.sv | 14 +
 rtl/inv_shift_rows_iter.sv | 113 +++++++++++
 tb/tb_inv_shift_rows_iter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte/row/state types used by the inverse round datapath.
// A state is indexed [row][col]; each row packs col 3 in the top byte.
package aes_pkg;

  localparam int NB = 4;

  typedef logic [7:0]       byte_t;
  typedef byte_t [NB-1:0]   row_t;
  typedef row_t  [NB-1:0]   state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } isr_state_e;

  // Right rotation: out[c] = row[(c - amt) mod 4]. The 2-bit cast performs the modulo.
  function automatic row_t inv_rotate_row(row_t row, int amt);
    row_t       r;
    logic [1:0] src;
    logic [1:0] dst;
    r = '0;
    for (int c = 0; c < NB; c++) begin
      dst    = 2'(c);
      src    = 2'(c - amt);
      r[dst] = row[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_row_rotate.sv
// Combinational right rotation of one state row by 0..3 byte positions.
module inv_row_rotate
  import aes_pkg::*;
(
  input  row_t       row_i,
  input  logic [1:0] amt_i,
  output row_t       row_o
);

  always_comb begin
    row_o = inv_rotate_row(row_i, int'(amt_i));
  end

endmodule

// File: rtl/inv_shift_rows_iter.sv
// AES InvShiftRows: row r rotated right by r. Iterative build processes one row
// per clock through a shared rotator; single-cycle build rotates all rows at once.
module inv_shift_rows_iter
  import aes_pkg::*;
#(
  parameter bit ITERATIVE = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  state_t in,
  output state_t state_out,
  output logic   done,
  output logic   busy,
  output logic   overrun
);

  state_t state_out_q;
  logic   done_q;
  logic   busy_q;
  logic   overrun_q;

  assign state_out = state_out_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

  if (ITERATIVE) begin : g_iter
    isr_state_e fsm_q;
    state_t     work_q;
    row_t       rot_in;
    row_t       rot_out;
    logic [1:0] rot_amt;

    // The FSM state number doubles as both the row index and the rotate amount.
    always_comb begin
      rot_amt = fsm_q;
      rot_in  = work_q[rot_amt];
    end

    inv_row_rotate u_rot (
      .row_i (rot_in),
      .amt_i (rot_amt),
      .row_o (rot_out)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        fsm_q       <= IDLE;
        work_q      <= '0;
        state_out_q <= '0;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
        overrun_q   <= 1'b0;
      end else begin
        case (fsm_q)
          IDLE: begin
            done_q <= 1'b0;
            if (enable) begin
              work_q <= in;
              busy_q <= 1'b1;
              fsm_q  <= ROW1;
            end
          end
          ROW1: begin
            work_q[1] <= rot_out;
            fsm_q     <= ROW2;
            if (enable) overrun_q <= 1'b1;
          end
          ROW2: begin
            work_q[2] <= rot_out;
            fsm_q     <= ROW3;
            if (enable) overrun_q <= 1'b1;
          end
          ROW3: begin
            state_out_q[2:0] <= work_q[2:0];
            state_out_q[3]   <= rot_out;
            done_q           <= 1'b1;
            busy_q           <= 1'b0;
            fsm_q            <= IDLE;
            if (enable) overrun_q <= 1'b1;
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end else begin : g_single
    state_t rot_all;

    for (genvar gi = 0; gi < NB; gi++) begin : g_row
      inv_row_rotate u_rot (
        .row_i (in[gi]),
        .amt_i (2'(gi)),
        .row_o (rot_all[gi])
      );
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_out_q <= '0;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
        overrun_q   <= 1'b0;
      end else begin
        busy_q    <= 1'b0;
        overrun_q <= 1'b0;
        done_q    <= enable;
        if (enable) state_out_q <= rot_all;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_iter.sv
// Scoreboard bench for both build modes of inv_shift_rows_iter against a
// matrix-level InvShiftRows / ShiftRows reference model.
module tb_inv_shift_rows_iter;

  typedef logic [3:0][3:0][7:0] st_t;
  typedef struct {
    st_t s;
    int  due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  st_t  din;
  st_t  so1, so0;
  logic done1, busy1, ovr1;
  logic done0, busy0, ovr0;

  exp_t q1[$];
  exp_t q0[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   remain = 0;
  logic ovr_exp = 1'b0;
  bit   mon_en = 1'b0;
  st_t  last1 = '0;
  st_t  last0 = '0;
  int   done1_cnt = 0;

  always #5 clk = ~clk;

  inv_shift_rows_iter #(.ITERATIVE(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in(din),
    .state_out(so1), .done(done1), .busy(busy1), .overrun(ovr1)
  );

  inv_shift_rows_iter #(.ITERATIVE(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in(din),
    .state_out(so0), .done(done0), .busy(busy0), .overrun(ovr0)
  );

  // out[r][c] = in[r][(c - r) mod 4]
  function automatic st_t inv_ref(st_t s);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[2'(r)][2'(c)] = s[2'(r)][2'((c - r + 4) % 4)];
    return o;
  endfunction

  // Encryption-side ShiftRows: out[r][c] = in[r][(c + r) mod 4]
  function automatic st_t shift_rows(st_t s);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[2'(r)][2'(c)] = s[2'(r)][2'((c + r) % 4)];
    return o;
  endfunction

  function automatic st_t rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected done behaviour at cycle %0d", name, cyc);
  endtask

  task automatic step(input logic en, input st_t d);
    enable = en;
    din    = d;
    @(negedge clk);
    #1;
  endtask

  // Reference model: samples inputs on every rising edge and schedules results.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      q1.delete();
      q0.delete();
      remain  = 0;
      ovr_exp = 1'b0;
      last1   = '0;
      last0   = '0;
      mon_en  = 1'b1;
    end else begin
      if (enable) q0.push_back('{inv_ref(din), cyc});
      if (remain == 0) begin
        if (enable) begin
          q1.push_back('{inv_ref(din), cyc + 3});
          remain = 3;
        end
      end else begin
        if (enable) ovr_exp = 1'b1;
        remain--;
      end
    end
  end

  // Monitor: compares every DUT output on each falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].due < cyc) begin
        report_fail("done1_missing");
        e = q1.pop_front();
      end
      if (done1) begin
        done1_cnt++;
        if (q1.size() > 0 && q1[0].due == cyc) begin
          e = q1.pop_front();
          last1 = e.s;
          check("data1", so1, e.s);
        end else report_fail("done1_spurious");
      end
      check("hold1", so1, last1);
      check("busy1", busy1, remain > 0);
      check("ovr1", ovr1, ovr_exp);

      if (q0.size() > 0 && q0[0].due < cyc) begin
        report_fail("done0_missing");
        e = q0.pop_front();
      end
      if (done0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
          e = q0.pop_front();
          last0 = e.s;
          check("data0", so0, e.s);
        end else report_fail("done0_spurious");
      end
      check("hold0", so0, last0);
      check("busy0", busy0, 1'b0);
      check("ovr0", ovr0, 1'b0);
    end
  end

  initial begin
    st_t pat, dexp, s_box, s_row, a, orig, h;
    int  c0;
    logic ebusy [6];

    reset  = 1'b1;
    enable = 1'b0;
    din    = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    check("rst_so1", so1, '0);
    check("rst_done1", done1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_ovr1", ovr1, 1'b0);
    check("rst_so0", so0, '0);

    // Directed 16*r+c pattern with literal expected rows.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pat[2'(r)][2'(c)] = 8'(16 * r + c);
    dexp = {32'h30333231, 32'h21202322, 32'h12111013, 32'h03020100};
    c0 = done1_cnt;
    step(1'b1, pat);
    check("dir_so0", so0, dexp);
    check("dir_done0", done0, 1'b1);
    step(1'b0, rnd());
    step(1'b0, rnd());
    check("dir_done1_early", done1, 1'b0);
    step(1'b0, rnd());
    check("dir_done1", done1, 1'b1);
    check("dir_so1", so1, dexp);
    step(1'b0, rnd());
    check("dir_done1_clr", done1, 1'b0);
    check("dir_done_count", done1_cnt - c0, 1);

    // FIPS-197 round 1: ShiftRows output maps back to the S-box output.
    s_box = {32'h30e5f1ae, 32'h525d9811, 32'h41b4bf27, 32'h1eb8e0d4};
    s_row = {32'he5f1ae30, 32'h9811525d, 32'h2741b4bf, 32'h1eb8e0d4};
    step(1'b1, s_row);
    check("fips_so0", so0, s_box);
    repeat (3) step(1'b0, rnd());
    check("fips_so1", so1, s_box);

    // Round trip through the encryption-side ShiftRows.
    for (int i = 0; i < 100; i++) begin
      orig = rnd();
      step(1'b1, shift_rows(orig));
      check("rt_so0", so0, orig);
      repeat (3) step(1'b0, rnd());
      check("rt_so1", so1, orig);
    end

    // Overrun: enable held for 6 cycles.
    repeat (2) step(1'b0, rnd());
    ebusy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    c0 = done1_cnt;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rnd());
      check("ovr_busy_pattern", busy1, ebusy[i]);
      if (i == 0) check("ovr_before", ovr1, 1'b0);
      if (i == 1) check("ovr_set", ovr1, 1'b1);
    end
    repeat (6) step(1'b0, rnd());
    check("ovr_completions", done1_cnt - c0, 2);
    check("ovr_sticky", ovr1, 1'b1);

    // Input changes while busy must not affect the result.
    a = rnd();
    step(1'b1, a);
    repeat (3) step(1'b0, rnd());
    check("inchg_so1", so1, inv_ref(a));

    // Reset while the iterative core is in ROW2.
    repeat (2) step(1'b0, rnd());
    c0 = done1_cnt;
    step(1'b1, rnd());
    step(1'b0, rnd());
    reset = 1'b1;
    step(1'b0, rnd());
    reset = 1'b0;
    check("rmid_so1", so1, '0);
    check("rmid_done1", done1, 1'b0);
    check("rmid_busy1", busy1, 1'b0);
    check("rmid_ovr1", ovr1, 1'b0);
    repeat (4) step(1'b0, rnd());
    check("rmid_no_done", done1_cnt - c0, 0);
    a = rnd();
    step(1'b1, a);
    repeat (3) step(1'b0, rnd());
    check("rmid_next_done", done1, 1'b1);
    check("rmid_next_so1", so1, inv_ref(a));

    // Idle hold with toggling inputs.
    h  = so1;
    c0 = done1_cnt;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rnd());
      check("idle_hold", so1, h);
      check("idle_done", done1, 1'b0);
    end
    check("idle_done_count", done1_cnt - c0, 0);

    repeat (5) step(1'b0, rnd());
    check("sb_q1_empty", q1.size(), 0);
    check("sb_q0_empty", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
